// File: rtl/sqrt_pipe_ctrl.sv
// Purpose : flow control and result collection for the pipelined square-root datapath.
// Latency : operand accepted at edge k shows as out_valid_o after edge k+STAGES when there is no stall.
// Backpr. : en_pipe_o/in_ready_o drop only when the 2-entry result buffer is full (registered, no out_ready_i path).
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid_i / in_ready_o operand handshake (in_ready_o == en_pipe_o)
//   en_pipe_o               shared advance enable for every datapath stage register
//   last_res_i              root result presented by the final datapath stage
//   out_valid_o/out_ready_i result handshake, out_res_o is the buffer head
//   busy_o, in_flight_o     status: anything pending / number of valid stages
module sqrt_pipe_ctrl #(
   parameter int STAGES    = 4,   // must be >= 2
   parameter int RES_WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   output logic                         en_pipe_o,
   input  logic [RES_WIDTH-1:0]         last_res_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [RES_WIDTH-1:0]         out_res_o,
   output logic                         busy_o,
   output logic [$clog2(STAGES+1)-1:0]  in_flight_o
);

   localparam int CNT_W = $clog2(STAGES + 1);

   localparam logic [1:0] BUF_EMPTY = 2'd0;
   localparam logic [1:0] BUF_ONE   = 2'd1;
   localparam logic [1:0] BUF_FULL  = 2'd2;

   // Per-stage valid bits shadowing the datapath registers.
   logic [STAGES-1:0]    vld_q,   vld_d;

   // Head-register FIFO: head_q is always the oldest entry, tail_q only
   // meaningful when two results are held.
   logic [1:0]           count_q, count_d;
   logic [RES_WIDTH-1:0] head_q,  head_d;
   logic [RES_WIDTH-1:0] tail_q,  tail_d;

   logic                 en_pipe;
   logic                 push;
   logic                 pop;
   logic [CNT_W-1:0]     in_flight;

   // Stall only on a full buffer. Because this depends on registered count
   // alone, a downstream pop frees the slot one cycle later rather than
   // combinationally, which keeps out_ready_i off the enable fan-out.
   assign en_pipe = (count_q != BUF_FULL);

   // A push can only happen while en_pipe is high, i.e. count < 2, so the
   // buffer cannot overflow.
   assign push = en_pipe && vld_q[STAGES-1];
   assign pop  = (count_q != BUF_EMPTY) && out_ready_i;

   // Valid shift: advances in lockstep with the datapath registers.
   always_comb begin
      vld_d = vld_q;
      if (en_pipe) begin
         vld_d = {vld_q[STAGES-2:0], in_valid_i};
      end
   end

   // Buffer next-state.
   always_comb begin
      count_d = count_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (count_q)
         BUF_EMPTY: begin
            if (push) begin
               head_d  = last_res_i;
               count_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (push && pop) begin
               // Head is consumed and replaced on the same edge.
               head_d = last_res_i;
            end else if (push) begin
               tail_d  = last_res_i;
               count_d = BUF_FULL;
            end else if (pop) begin
               count_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = BUF_ONE;
            end
         end
         default: begin
            count_d = BUF_EMPTY;
         end
      endcase
   end

   // Population count of the stage valid bits.
   always_comb begin
      in_flight = '0;
      for (int i = 0; i < STAGES; i++) begin
         in_flight = in_flight + CNT_W'(vld_q[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q   <= '0;
         count_q <= BUF_EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         vld_q   <= vld_d;
         count_q <= count_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   assign en_pipe_o   = en_pipe;
   assign in_ready_o  = en_pipe;
   assign out_valid_o = (count_q != BUF_EMPTY);
   assign out_res_o   = head_q;
   assign busy_o      = (|vld_q) || (count_q != BUF_EMPTY);
   assign in_flight_o = in_flight;

endmodule

// File: doc/sqrt_pipe_ctrl.md
Name: sqrt_pipe_ctrl

Overview:
- Flow-control and result-collection block for the pipelined square-root datapath.
- Accepts operands via a valid/ready handshake and generates the shared `en_pipe_o` stall enable that drives every stage's `en_pipe_i`.
- Tracks a per-stage valid bit alongside the data registers.
- Captures the final-stage result into a 2-entry output buffer drained by a downstream valid/ready handshake.

Parameters:
- STAGES, 4, number of pipeline register stages between operand entry and final result (>=2).
- RES_WIDTH, 8, width of the root result taken from the last stage.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid_i  input  1  upstream operand valid.
- in_ready_o  output  1  operand accepted on an edge where in_valid_i && in_ready_o.
- en_pipe_o  output  1  advance enable to all datapath stage registers.
- last_res_i  input  RES_WIDTH  result bus from the last datapath stage.
- out_valid_o  output  1  buffer head holds a result.
- out_ready_i  input  1  downstream consumes head when out_valid_o && out_ready_i.
- out_res_o  output  RES_WIDTH  buffer head data.
- busy_o  output  1  any stage valid bit set or buffer non-empty.
- in_flight_o  output  $clog2(STAGES+1)  number of set stage valid bits.

Behaviour:
- Reset (rst_n=0 at an edge):
  - vld[STAGES-1:0]=0, buffer count=0, both buffer entries=0.
  - Outputs after reset: out_valid_o=0, out_res_o=0, busy_o=0, in_flight_o=0, en_pipe_o=1, in_ready_o=1.
  - Reset mid-operation discards all in-flight operands and buffered results.
- Enable:
  - `en_pipe_o = (count != 2)`. This is a function of registered state only; there is no combinational path from out_ready_i.
  - `in_ready_o = en_pipe_o`.
- Valid shift on an edge with en_pipe_o=1:
  - vld[0] <= in_valid_i.
  - vld[i] <= vld[i-1] for i>=1.
  - With en_pipe_o=0, vld holds. This matches the datapath registers holding.
- Capture:
  - push = en_pipe_o && vld[STAGES-1]. last_res_i is written into the buffer at that edge.
  - push is never asserted when count==2, so overflow is impossible by construction.
- Pop: pop = out_valid_o && out_ready_i. out_ready_i with an empty buffer has no effect.
- Buffer:
  - 2-entry FIFO, head-register organisation.
  - count 0->1 on push only; 1->2 on push without pop; 2->1 on pop only; 1->0 on pop only.
  - Simultaneous push+pop: count unchanged. At count==1 the head becomes the new data; at count==2 the second entry moves to head (push impossible at 2).
  - out_valid_o = (count != 0). out_res_o = head entry.
- Latency: with no stall, an operand accepted at edge k appears as out_valid_o=1 after edge k+STAGES (STAGES+1 cycles including acceptance).
- Throughput: one operand per cycle while downstream drains each cycle.
- Order: results emerge strictly in acceptance order. Bubbles (in_valid_i=0) propagate as vld=0 and are never pushed.
- Status: busy_o = |vld || count!=0. in_flight_o = popcount(vld).

Test Plan:
- Reset: hold rst_n=0 with in_valid_i=1 → vld all 0, out_valid_o=0, out_res_o=0, en_pipe_o=1 after release.
- Single op (STAGES=4): accept at edge 0, last_res_i=8'h0C when vld[3] → out_valid_o rises after edge 4, out_res_o=8'h0C, in_flight_o peaks at 1.
- Back-pressure: stream 6 operands with out_ready_i=0 → buffer fills to 2, en_pipe_o=0, in_flight_o holds at 4, nothing dropped; release out_ready_i → 6 results in order.
- Simultaneous push/pop at count==1 → count stays 1, head updates to new result the same edge.
- Bubbles: in_valid_i pattern 1,0,1 → exactly 2 results, spaced 2 cycles apart.
- Mid-operation reset with 3 in flight and 2 buffered → all cleared, busy_o=0 the cycle after the reset edge.
